// File: rtl/iter_shifter_pkg.sv
// Shared encodings for the iterative shifter: op codes, FSM states, default sizes.
package iter_shifter_pkg;

  localparam int WIDTH_DEF   = 32;
  localparam int SHAMT_W_DEF = 5;

  // Reserved op code behaves as SLL.
  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/iter_shifter_shift_stage.sv
// One log-shifter stage: conditionally shifts by 2^k in the direction given by op.
module shift_stage
  import iter_shifter_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
) (
  input  logic [WIDTH-1:0]   in,
  input  op_e                op,
  input  logic [SHAMT_W-1:0] k,
  input  logic               en,
  output logic [WIDTH-1:0]   out
);

  logic [SHAMT_W-1:0] sh;

  // Stage distance is 2^k; the largest stage (2^(SHAMT_W-1)) still fits SHAMT_W bits.
  always_comb begin
    sh  = SHAMT_W'(1) << k;
    out = in;
    if (en) begin
      case (op)
        OP_SRL:  out = in >> sh;
        OP_SRA:  out = $signed(in) >>> sh;
        default: out = in << sh;   // SLL and reserved
      endcase
    end
  end

endmodule

// File: rtl/iter_shifter.sv
// Multicycle shift unit: applies one log-shifter stage per cycle, MSB stage first,
// so every op takes exactly SHAMT_W shift cycles followed by a one-cycle RDY.
module iter_shifter
  import iter_shifter_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ctrl_start,
  input  logic [1:0]         ctrl_op,
  input  logic [WIDTH-1:0]   data_operandA,
  input  logic [SHAMT_W-1:0] ctrl_shiftamt,
  output logic [WIDTH-1:0]   data_result,
  output logic               data_resultRDY,
  output logic               busy
);

  state_e             state_q, state_d;
  logic [SHAMT_W-1:0] stage_q, stage_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [SHAMT_W-1:0] amt_q, amt_d;
  op_e                op_q, op_d;

  logic [WIDTH-1:0]   stage_out;
  logic               stage_en;

  assign stage_en = amt_q[stage_q];

  shift_stage #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_stage (
    .in  (acc_q),
    .op  (op_q),
    .k   (stage_q),
    .en  (stage_en),
    .out (stage_out)
  );

  // State and operand registers; reset aborts any in-flight op and zeroes the result.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      stage_q <= '0;
      acc_q   <= '0;
      amt_q   <= '0;
      op_q    <= OP_SLL;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      acc_q   <= acc_d;
      amt_q   <= amt_d;
      op_q    <= op_d;
    end
  end

  // Next-state: accept in IDLE/DONE, one stage per SHIFT cycle, DONE after stage 0.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    acc_d   = acc_q;
    amt_d   = amt_q;
    op_d    = op_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (ctrl_start) begin
          state_d = ST_SHIFT;
          acc_d   = data_operandA;
          amt_d   = ctrl_shiftamt;
          op_d    = op_e'(ctrl_op);
          stage_d = SHAMT_W'(SHAMT_W - 1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        // Start requests are ignored here; the in-flight op runs to completion.
        acc_d   = stage_out;
        stage_d = stage_q - 1'b1;
        if (stage_q == '0) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign data_result    = acc_q;
  assign data_resultRDY = (state_q == ST_DONE);
  assign busy           = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_iter_shifter.sv
// Scoreboard bench for iter_shifter: expected results are queued at issue and
// popped when RDY is observed.
module tb_iter_shifter;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;
  localparam int LAT     = SHAMT_W + 1;

  logic               clock = 1'b0;
  logic               reset;
  logic               ctrl_start;
  logic [1:0]         ctrl_op;
  logic [WIDTH-1:0]   data_operandA;
  logic [SHAMT_W-1:0] ctrl_shiftamt;
  logic [WIDTH-1:0]   data_result;
  logic               data_resultRDY;
  logic               busy;

  int checks   = 0;
  int failures = 0;
  logic [WIDTH-1:0] sb[$];

  iter_shifter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_start     (ctrl_start),
    .ctrl_op        (ctrl_op),
    .data_operandA  (data_operandA),
    .ctrl_shiftamt  (ctrl_shiftamt),
    .data_result    (data_result),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  function automatic logic [WIDTH-1:0] model(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                             input logic [SHAMT_W-1:0] amt);
    case (op)
      2'b01:   return a >> amt;
      2'b10:   return WIDTH'($signed(a) >>> amt);
      default: return a << amt;
    endcase
  endfunction

  // Drive a start pulse at a negedge; returns just after the accepting posedge.
  task automatic issue(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [SHAMT_W-1:0] amt);
    @(negedge clock);
    ctrl_start = 1'b1; ctrl_op = op; data_operandA = a; ctrl_shiftamt = amt;
    sb.push_back(model(op, a, amt));
    @(posedge clock); #1;
    ctrl_start = 1'b0;
    data_operandA = ~a;         // operands may change after accept
    ctrl_shiftamt = ~amt;
  endtask

  // Wait for RDY after an accept; checks busy/latency, pops and compares result.
  task automatic wait_result(input string name);
    int n; logic [WIDTH-1:0] exp;
    n = 0;
    while (1) begin
      @(negedge clock);
      n++;
      if (data_resultRDY === 1'b1 || n > 20) break;
      checks++;
      if (busy !== 1'b1) begin
        failures++; $display("FAIL %s busy cyc%0d got=%b want=1", name, n, busy);
      end
    end
    checks++;
    if (n !== LAT) begin
      failures++; $display("FAIL %s latency got=%0d want=%0d", name, n, LAT);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL %s busy_in_done got=%b want=0", name, busy);
    end
    exp = (sb.size() > 0) ? sb.pop_front() : 'x;
    checks++;
    if (data_result !== exp) begin
      failures++; $display("FAIL %s result got=%h want=%h", name, data_result, exp);
    end
  endtask

  task automatic check_rdy_drop(input string name, input logic [WIDTH-1:0] held);
    @(negedge clock);
    checks++;
    if (data_resultRDY !== 1'b0 || data_result !== held) begin
      failures++; $display("FAIL %s after_done rdy=%b res=%h want rdy=0 res=%h",
                           name, data_resultRDY, data_result, held);
    end
  endtask

  task automatic test_reset();
    int rdy_seen;
    reset = 1'b1; ctrl_start = 1'b0; ctrl_op = 2'b00; data_operandA = '0; ctrl_shiftamt = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checks++;
    if (data_result !== '0 || data_resultRDY !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL reset_state res=%h rdy=%b busy=%b want 0/0/0",
                           data_result, data_resultRDY, busy);
    end
    rdy_seen = 0;
    repeat (10) begin @(negedge clock); if (data_resultRDY !== 1'b0) rdy_seen++; end
    checks++;
    if (rdy_seen != 0) begin
      failures++; $display("FAIL reset_idle rdy_pulses got=%0d want=0", rdy_seen);
    end
  endtask

  task automatic test_sll_basic();
    issue(2'b00, 32'h0000_0001, 5'd4);
    wait_result("sll_basic");
    check_rdy_drop("sll_basic", 32'h0000_0010);
  endtask

  task automatic test_extremes();
    issue(2'b10, 32'h8000_0000, 5'd31); wait_result("sra_31");
    issue(2'b01, 32'h8000_0000, 5'd31); wait_result("srl_31");
    issue(2'b00, 32'h8000_0000, 5'd31); wait_result("sll_31");
    issue(2'b11, 32'h0000_0003, 5'd2);  wait_result("rsv_as_sll");
    issue(2'b10, 32'h7000_0000, 5'd3);  wait_result("sra_pos");
    issue(2'b10, 32'hC123_4567, 5'd21); wait_result("sra_mixed");
    issue(2'b01, 32'hF0F0_1234, 5'd13); wait_result("srl_mixed");
  endtask

  task automatic test_amt_zero();
    issue(2'b01, 32'hDEAD_BEEF, 5'd0);
    wait_result("srl_amt0");
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] exp;
    issue(2'b00, 32'h0000_000F, 5'd1);
    @(negedge clock);                 // cycle 1 of SHIFT
    ctrl_start = 1'b1; ctrl_op = 2'b00; data_operandA = 32'h1; ctrl_shiftamt = 5'd8;
    @(negedge clock);
    ctrl_start = 1'b0;
    // Wait for DONE of op one (accept + 6 negedges; 2 already consumed).
    repeat (LAT - 2) @(negedge clock);
    checks++;
    if (data_resultRDY !== 1'b1) begin
      failures++; $display("FAIL b2b_first rdy got=%b want=1", data_resultRDY);
    end
    exp = (sb.size() > 0) ? sb.pop_front() : 'x;
    checks++;
    if (data_result !== exp) begin
      failures++; $display("FAIL b2b_first result got=%h want=%h", data_result, exp);
    end
    // Issue in the DONE cycle.
    ctrl_start = 1'b1; ctrl_op = 2'b10; data_operandA = 32'hFFFF_FF00; ctrl_shiftamt = 5'd4;
    sb.push_back(model(2'b10, 32'hFFFF_FF00, 5'd4));
    @(posedge clock); #1;
    ctrl_start = 1'b0;
    wait_result("b2b_second");
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("FAIL b2b_queue leftover got=%0d want=0", sb.size());
    end
  endtask

  task automatic test_reset_abort();
    int rdy_seen;
    issue(2'b00, 32'h0000_0001, 5'd31);
    repeat (3) @(negedge clock);     // after edge N+3
    reset = 1'b1;
    sb.delete();
    #1;
    checks++;
    if (busy !== 1'b0 || data_result !== '0 || data_resultRDY !== 1'b0) begin
      failures++; $display("FAIL abort_state busy=%b res=%h rdy=%b want 0/0/0",
                           busy, data_result, data_resultRDY);
    end
    @(posedge clock); #1 reset = 1'b0;
    rdy_seen = 0;
    repeat (10) begin @(negedge clock); if (data_resultRDY !== 1'b0 || busy !== 1'b0) rdy_seen++; end
    checks++;
    if (rdy_seen != 0) begin
      failures++; $display("FAIL abort_quiet active_cycles got=%0d want=0", rdy_seen);
    end
    checks++;
    if (data_result !== '0) begin
      failures++; $display("FAIL abort_result got=%h want=0", data_result);
    end
  endtask

  task automatic test_random();
    logic [1:0] op; logic [WIDTH-1:0] a; logic [SHAMT_W-1:0] amt;
    for (int i = 0; i < 20; i++) begin
      op = 2'($urandom_range(0, 3)); a = $urandom; amt = 5'($urandom_range(0, 31));
      issue(op, a, amt);
      wait_result("random");
    end
  endtask

  initial begin
    test_reset();
    test_sll_basic();
    test_extremes();
    test_amt_zero();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
